// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared arbiter FSM state encoding and index-width helper
package spi_arb_pkg;
  typedef enum logic [1:0] {IDLE, START, BUSY, ACK} state_t;
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// rr_picker: combinational round-robin pick of the first set req bit above last, wrapping (req,last -> valid,winner)
module rr_picker #(
  parameter int N_REQ = 2,
  parameter int IW = 1
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    winner
);
  logic [N_REQ-1:0] hi, pool;
  always_comb begin
    hi = '0;
    for (int i = 0; i < N_REQ; i++) hi[i] = i > int'(last);
    pool = |(req & hi) ? req & hi : req;
    winner = '0;
    for (int i = N_REQ - 1; i >= 0; i--) if (pool[i]) winner = IW'(i);
  end
  assign valid = |req;
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin share of one SPI master (req/req_tx in; gnt/ack/err/rx_data out; spi_ready/done/rx in, spi_start/tx out)
module spi_arbiter
  import spi_arb_pkg::*;
#(
  parameter int N_REQ = 2,
  parameter int DATA_W = 8,
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] req_tx,
  output logic [N_REQ-1:0]        gnt,
  output logic [N_REQ-1:0]        ack,
  output logic                    err,
  output logic [DATA_W-1:0]       rx_data,
  input  logic                    spi_ready,
  output logic                    spi_start,
  output logic [DATA_W-1:0]       spi_tx,
  input  logic                    spi_done,
  input  logic [DATA_W-1:0]       spi_rx
);
  localparam int IW = idx_w(N_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  state_t state, state_n;
  logic [IW-1:0] idx, last, win;
  logic [CW-1:0] cnt;
  logic [DATA_W-1:0] tx_sel;
  logic [N_REQ-1:0] sel;
  logic valid, err_q, timeout;
  rr_picker #(.N_REQ(N_REQ), .IW(IW)) u_pick (
    .req(req),
    .last(last),
    .valid(valid),
    .winner(win)
  );
  always_comb begin
    tx_sel = '0;
    for (int i = 0; i < N_REQ; i++) if (win == IW'(i)) tx_sel = req_tx[i*DATA_W +: DATA_W];
  end
  assign timeout = cnt == CW'(TIMEOUT_CYC - 1);
  assign sel = N_REQ'(1) << idx;
  assign gnt = (state != IDLE) ? sel : '0;
  assign ack = (state == ACK) ? sel : '0;
  assign err = (state == ACK) && err_q;
  assign spi_start = state == START;
  always_comb
    state_n = (state == IDLE)  ? ((valid && spi_ready) ? START : IDLE) :
              (state == START) ? BUSY :
              (state == BUSY)  ? ((spi_done || timeout) ? ACK : BUSY) : IDLE;
  always_ff @(posedge clk) state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      last <= IW'(N_REQ - 1);
      cnt <= '0;
      spi_tx <= '0;
      rx_data <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == IDLE && valid && spi_ready) begin
        idx <= win;
        spi_tx <= tx_sel;
      end
      if (state == START) cnt <= '0;
      if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (spi_done) begin
          rx_data <= spi_rx;
          err_q <= 1'b0;
        end else if (timeout) begin
          rx_data <= '0;
          err_q <= 1'b1;
        end
      end
      if (state == ACK) last <= idx;
    end
  end
endmodule
